jk_drive_seq: RTL

- Command-driven sequencer that sits directly upstream of the JK flip-flop and generates its J/K inputs.
- Accepts operation commands (hold/reset/set/toggle plus a repeat count) over a valid/ready handshake.
- Drives the matching J/K pattern for exactly that many clock cycles.
- Keeps a reference model of the flop's Q and can check the flop's real output against it.

---
 rtl/jk_drive_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/jk_drive_seq.sv
// Command-driven J/K sequencer feeding a JK flip-flop, with a reference model of Q.
// Define JK_CHECK_EN to enable the sticky q_in vs q_exp mismatch flag (err).
module jk_drive_seq #(
  parameter int CW = 4
) (
  input  logic          Clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_cnt,
  output logic          J,
  output logic          K,
  input  logic          q_in,
  output logic          q_exp,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          j_q, j_d;
  logic          k_q, k_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          q_exp_q, q_exp_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;

`ifndef JK_CHECK_EN
  logic unused_q_in;
  assign unused_q_in = q_in;
`endif

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    ready_d = ready_q;

    // Model follows the J/K the flop samples at this same edge
    case ({j_q, k_q})
      2'b01:   q_exp_d = 1'b0;
      2'b10:   q_exp_d = 1'b1;
      2'b11:   q_exp_d = ~q_exp_q;
      default: q_exp_d = q_exp_q;
    endcase

`ifdef JK_CHECK_EN
    err_d = err_q | (q_in != q_exp_q);
`else
    err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          j_d     = cmd_op[1];
          k_d     = cmd_op[0];
          rem_d   = (cmd_cnt == '0) ? CW'(1) : cmd_cnt;
          state_d = DRIVE;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      DRIVE: begin
        if (rem_q > CW'(1)) begin
          rem_d = rem_q - CW'(1);
        end else begin
          j_d     = 1'b0;
          k_d     = 1'b0;
          rem_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        j_d     = 1'b0;
        k_d     = 1'b0;
        rem_d   = '0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!rst) begin
      state_q <= IDLE;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      rem_q   <= '0;
      q_exp_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
      q_exp_q <= q_exp_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign J         = j_q;
  assign K         = k_q;
  assign q_exp     = q_exp_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign cmd_ready = ready_q;

endmodule
